branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter DEPTH, default 16, number of BTB entries; a power of two, 2..256.
REQ-002 Parameter CNT_W, default 2, width of each saturating direction counter; 1..4.
REQ-003 Parameter PC_W, default 32, width of instruction addresses.
REQ-004 Port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1; synchronous active-high reset, sampled on the rising edge of clk.
REQ-006 Port pc, input, PC_W, fetch address being looked up this cycle.
REQ-007 Port pred_taken, output, 1, lookup predicts taken.
REQ-008 Port pred_pc, output, PC_W, predicted next fetch address.
REQ-009 Port upd_en, input, 1, a branch or jump resolved in EX this cycle.
REQ-010 Port upd_pc, input, PC_W, address of the resolved instruction.
REQ-011 Port upd_taken, input, 1, actual outcome.
REQ-012 Port upd_target, input, PC_W, actual taken target.
REQ-013 Port upd_mispredict, input, 1, EX detected a wrong prediction; qualified by upd_en.
REQ-014 Port hit_cnt, output, 32, count of updates whose pc hit a valid entry.
REQ-015 Port mispred_cnt, output, 32, count of qualified mispredicts.

Function
REQ-016 Entry fields: valid, tag, target (PC_W), counter (CNT_W); direct-mapped.
REQ-017 Index = addr[log2(DEPTH)+1:2]; tag = addr[PC_W-1:log2(DEPTH)+2]; addr[1:0] ignored.
REQ-018 Lookup is combinational, zero latency: hit = valid & tag match at index(pc).
REQ-019 pred_taken = hit & counter MSB; pred_pc = target if pred_taken, else pc+4 (mod 2^PC_W).
REQ-020 Update on a clock edge with upd_en=1; result visible to lookups from the next cycle.
REQ-021 Update hit, upd_taken=1: counter increments, saturating at all-ones; target := upd_target.
REQ-022 Update hit, upd_taken=0: counter decrements, saturating at zero; target unchanged.
REQ-023 Update miss, upd_taken=1: allocate/overwrite entry; valid=1, new tag, target=upd_target, counter = weakly taken (MSB=1, rest 0).
REQ-024 Update miss, upd_taken=0: no state change.
REQ-025 Same-cycle lookup and update, same index: lookup returns pre-update state (read before write).
REQ-026 hit_cnt increments by 1 per upd_en with hit; mispred_cnt increments by 1 per upd_en & upd_mispredict; both wrap 0xFFFFFFFF -> 0.
REQ-027 upd_mispredict without upd_en is ignored.
REQ-028 CNT_W=1: counter is a last-outcome bit; allocate value 1.

Reset
REQ-029 On reset all valid bits clear; counters := weakly not-taken (MSB=0, rest 1); targets and tags := 0.
REQ-030 During a reset cycle the update is discarded; hit_cnt and mispred_cnt := 0.
REQ-031 Out of reset, every lookup misses: pred_taken=0, pred_pc=pc+4.
REQ-032 Reset asserted mid-operation takes priority over any same-cycle update.

Verification
REQ-033 After reset, pc=0x00000040 -> pred_taken=0, pred_pc=0x00000044.
REQ-034 Update pc=0x40, taken=1, target=0x100 -> next cycle lookup 0x40 gives pred_taken=1, pred_pc=0x100; the DEPTH=16 counter reads 2'b10.
REQ-035 Three not-taken updates at 0x40 -> counter saturates at 2'b00; a fourth keeps 00; lookup 0x40 gives pred_pc=0x44.
REQ-036 Aliasing, DEPTH=16: train 0x40 taken, then taken update at 0x80 (same index, different tag) -> 0x40 now misses and 0x80 hits.
REQ-037 Same-cycle update and lookup of 0x40 after reset -> lookup shows miss that cycle and hit the next cycle.
REQ-038 Preload mispred_cnt to 0xFFFFFFFF via 2^32-1 qualified mispredicts, or force it; one more mispredict -> 0. Reset asserted with upd_en=1 -> counters 0, no allocation.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is combinational on pc; training happens on the rising
// edge when upd_en is asserted. hit_cnt and mispred_cnt are wrapping
// 32-bit statistics counters.
module branch_predictor #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 2,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_pc,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_mispredict,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;

  // Weakly not-taken: MSB clear, remaining bits set (0 when CNT_W=1).
  localparam logic [CNT_W-1:0] CNT_WNT = {CNT_W{1'b1}} >> 1;
  // Weakly taken: only the MSB set (1 when CNT_W=1).
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);

  logic             r_valid  [DEPTH];
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [PC_W-1:0]  r_target [DEPTH];
  logic [CNT_W-1:0] r_cnt    [DEPTH];

  logic [31:0] r_hit_cnt;
  logic [31:0] r_mispred_cnt;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;

  logic [IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_uhit;
  logic [CNT_W-1:0] w_ucnt;

  assign w_idx  = pc[IDX_W+1:2];
  assign w_tag  = pc[PC_W-1:IDX_W+2];
  assign w_uidx = upd_pc[IDX_W+1:2];
  assign w_utag = upd_pc[PC_W-1:IDX_W+2];
  assign w_ucnt = r_cnt[w_uidx];

  assign hit_cnt     = r_hit_cnt;
  assign mispred_cnt = r_mispred_cnt;

  // Lookup: reads current (pre-update) table state, so a same-cycle
  // update to the same index is not visible until the next cycle.
  always_comb begin
    w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_uhit     = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    pred_taken = w_hit && r_cnt[w_idx][CNT_W-1];
    pred_pc    = pred_taken ? r_target[w_idx] : (pc + PC_W'(4));
  end

  // Table training and statistics; reset overrides any same-cycle update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i[IDX_W-1:0]]  <= 1'b0;
        r_tag[i[IDX_W-1:0]]    <= '0;
        r_target[i[IDX_W-1:0]] <= '0;
        r_cnt[i[IDX_W-1:0]]    <= CNT_WNT;
      end
      r_hit_cnt     <= '0;
      r_mispred_cnt <= '0;
    end else if (upd_en) begin
      if (w_uhit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
        if (upd_taken) begin
          if (w_ucnt != '1) r_cnt[w_uidx] <= w_ucnt + CNT_W'(1);
          r_target[w_uidx] <= upd_target;
        end else if (w_ucnt != '0) begin
          r_cnt[w_uidx] <= w_ucnt - CNT_W'(1);
        end
      end else if (upd_taken) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= upd_target;
        r_cnt[w_uidx]    <= CNT_WT;
      end
      if (upd_mispredict) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor (DEPTH=16, CNT_W=2, PC_W=32): directed cases
// with literal expectations, then randomized traffic against a table model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] hit_cnt;
  logic [31:0] mispred_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.DEPTH(16), .CNT_W(2), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .hit_cnt(hit_cnt),
    .mispred_cnt(mispred_cnt)
  );

  // Reference model: one record per table slot, counter as a plain integer 0..3.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  logic [31:0] m_hits;
  logic [31:0] m_mis;

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic logic [31:0] tagof(input logic [31:0] a);
    return a >> 6;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[slot(a)] && (m_tag[slot(a)] == tagof(a));
  endfunction

  task automatic m_apply(input bit rst, input bit ue, input logic [31:0] up,
                         input bit ut, input logic [31:0] utg, input bit um);
    int s;
    s = slot(up);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
      end
      m_hits = 0; m_mis = 0;
    end else if (ue) begin
      if (m_hit(up)) begin
        m_hits = m_hits + 1;
        if (ut) begin
          m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
          m_tgt[s] = utg;
        end else begin
          m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[s] = 1; m_tag[s] = tagof(up); m_tgt[s] = utg; m_cnt[s] = 2;
      end
      if (um) m_mis = m_mis + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model for the pc currently driven.
  task automatic compare_model();
    bit          t;
    logic [31:0] npc;
    t   = m_hit(pc) && (m_cnt[slot(pc)] >= 2);
    npc = t ? m_tgt[slot(pc)] : pc + 32'd4;
    chk("model_pred_taken", {31'd0, pred_taken}, {31'd0, t});
    chk("model_pred_pc", pred_pc, npc);
    chk("model_hit_cnt", hit_cnt, m_hits);
    chk("model_mispred_cnt", mispred_cnt, m_mis);
  endtask

  // One cycle: drive inputs after the falling edge, compare, then train the model.
  task automatic step(input bit rst, input logic [31:0] p, input bit ue,
                      input logic [31:0] up, input bit ut,
                      input logic [31:0] utg, input bit um);
    @(negedge clk);
    reset = rst; pc = p; upd_en = ue; upd_pc = up;
    upd_taken = ut; upd_target = utg; upd_mispredict = um;
    #1;
    compare_model();
    @(posedge clk);
    m_apply(rst, ue, up, ut, utg, um);
  endtask

  // Drive a lookup only and leave outputs settled for literal checks.
  task automatic peek(input logic [31:0] p);
    @(negedge clk);
    reset = 0; pc = p; upd_en = 0; upd_mispredict = 0; upd_taken = 0;
    #1;
    compare_model();
  endtask

  function automatic logic [31:0] pool(input int k);
    case (k)
      0: return 32'h0000_0040;
      1: return 32'h0000_0080;
      2: return 32'h0000_0044;
      3: return 32'h0000_1040;
      4: return 32'h0000_0100;
      5: return 32'hFFFF_FFFC;
      6: return 32'h0000_0048;
      default: return 32'h0000_2044;
    endcase
  endfunction

  initial begin
    reset = 1; pc = 0; upd_en = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_mispredict = 0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_hits = 0; m_mis = 0;

    // Reset, then cold lookup misses.
    @(posedge clk);
    step(1, 32'h40, 0, 0, 0, 0, 0);
    peek(32'h40);
    chk("cold_taken", {31'd0, pred_taken}, 32'd0);
    chk("cold_pc", pred_pc, 32'h44);
    chk("cold_hits", hit_cnt, 32'd0);

    // Allocate 0x40 -> 0x100; same-cycle lookup shows the old (miss) state.
    step(0, 32'h40, 1, 32'h40, 1, 32'h100, 1);
    peek(32'h40);
    chk("alloc_taken", {31'd0, pred_taken}, 32'd1);
    chk("alloc_pc", pred_pc, 32'h100);
    chk("alloc_mis", mispred_cnt, 32'd1);
    chk("alloc_hits", hit_cnt, 32'd0);

    // Counter was weakly taken: one not-taken drops prediction.
    step(0, 32'h40, 1, 32'h40, 0, 32'h0, 0);
    peek(32'h40);
    chk("weak_taken", {31'd0, pred_taken}, 32'd0);
    chk("weak_pc", pred_pc, 32'h44);
    chk("weak_hits", hit_cnt, 32'd1);

    // Saturate low: three more not-taken, then one taken must stay not-taken.
    for (int i = 0; i < 3; i++) step(0, 32'h80, 1, 32'h40, 0, 32'h0, 0);
    step(0, 32'h80, 1, 32'h40, 1, 32'h200, 0);
    peek(32'h40);
    chk("sat_low_taken", {31'd0, pred_taken}, 32'd0);
    chk("sat_low_pc", pred_pc, 32'h44);
    chk("sat_low_hits", hit_cnt, 32'd5);

    // Saturate high: many taken, one not-taken still predicts taken.
    for (int i = 0; i < 5; i++) step(0, 32'h40, 1, 32'h40, 1, 32'h300, 0);
    step(0, 32'h40, 1, 32'h40, 0, 32'h0, 0);
    peek(32'h40);
    chk("sat_high_taken", {31'd0, pred_taken}, 32'd1);
    chk("sat_high_pc", pred_pc, 32'h300);

    // Aliasing: 0x80 shares the slot with 0x40 and evicts it.
    step(0, 32'h40, 1, 32'h80, 1, 32'h500, 0);
    peek(32'h40);
    chk("alias_old_taken", {31'd0, pred_taken}, 32'd0);
    chk("alias_old_pc", pred_pc, 32'h44);
    peek(32'h80);
    chk("alias_new_pc", pred_pc, 32'h500);

    // Miss with not-taken leaves state untouched; mispredict without upd_en ignored.
    step(0, 32'h0, 1, 32'h1000, 0, 32'h700, 0);
    step(0, 32'h0, 0, 32'h1000, 1, 32'h700, 1);
    peek(32'h1000);
    chk("nt_miss_pc", pred_pc, 32'h1004);
    chk("unq_mis", mispred_cnt, 32'd1);

    // pc+4 wraps at the top of the address space.
    peek(32'hFFFF_FFFC);
    chk("wrap_pc", pred_pc, 32'h0);

    // mispred_cnt wraps from all-ones to zero.
    @(negedge clk);
    force dut.r_mispred_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_mispred_cnt;
    m_mis = 32'hFFFF_FFFF;
    step(0, 32'h0, 1, 32'h3000, 0, 32'h0, 1);
    peek(32'h0);
    chk("mis_wrap", mispred_cnt, 32'd0);

    // Reset with a taken update: no allocation, counters cleared.
    step(1, 32'h0, 1, 32'h2040, 1, 32'h900, 1);
    peek(32'h2040);
    chk("rst_upd_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_upd_pc", pred_pc, 32'h2044);
    chk("rst_upd_hits", hit_cnt, 32'd0);
    chk("rst_upd_mis", mispred_cnt, 32'd0);
    peek(32'h80);
    chk("rst_clears_80", pred_pc, 32'h84);

    // Randomized traffic over a small address pool so entries collide and hit.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] p, u, tg;
      p  = pool(int'($urandom_range(0, 7))) | 32'($urandom_range(0, 3));
      u  = pool(int'($urandom_range(0, 7))) | 32'($urandom_range(0, 3));
      tg = $urandom;
      step(($urandom_range(0, 63) == 0), p, bit'($urandom_range(0, 1)), u,
           bit'($urandom_range(0, 1)), tg, bit'($urandom_range(0, 1)));
    end
    peek(32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
